task_result_collector: RTL and testbench

TASK_RESULT_COLLECTOR -- requirements
Module: task_result_collector

---
 rtl/task_result_collector_if.sv | 34 +++
 rtl/task_result_collector.sv | 95 +++++++++
 tb/tb_task_result_collector.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/task_result_collector_if.sv
// Handshake bundle between the task distributor, the compute workers and the
// in-order result collector.
//   issue_vld / issue_id     : distributor launched a task on worker issue_id
//   wrk_res_vld / wrk_res    : per-worker one-cycle result pulse and data
//                              (worker k on wrk_res[k*W +: W])
//   res_vld / res            : in-order result strobe and data
//   busy                     : at least one task outstanding
//   err                      : sticky protocol-violation flag
// master drives the issue/result inputs; slave is the collector.
interface task_result_collector_if #(
  parameter int N_WORKERS = 4,
  parameter int W         = 32
);
  localparam int IDW = ($clog2(N_WORKERS) < 1) ? 1 : $clog2(N_WORKERS);

  logic                   issue_vld;
  logic [IDW-1:0]         issue_id;
  logic [N_WORKERS-1:0]   wrk_res_vld;
  logic [N_WORKERS*W-1:0] wrk_res;
  logic                   res_vld;
  logic [W-1:0]           res;
  logic                   busy;
  logic                   err;

  modport master (
    output issue_vld, issue_id, wrk_res_vld, wrk_res,
    input  res_vld, res, busy, err
  );

  modport slave (
    input  issue_vld, issue_id, wrk_res_vld, wrk_res,
    output res_vld, res, busy, err
  );
endinterface

// File: rtl/task_result_collector.sv
// Reorders results from N_WORKERS out-of-order workers back into issue order.
// An issue-order FIFO of worker IDs tracks launch order; each worker owns one
// result slot plus a full flag. Whenever the FIFO head's slot is full, the
// result is emitted (registered) and the head is popped.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : task_result_collector_if.slave (issue, worker results, in-order
//          result stream, busy, sticky err)
module task_result_collector #(
  parameter int N_WORKERS = 4,
  parameter int W         = 32
) (
  input logic                    clk,
  input logic                    rst,
  task_result_collector_if.slave bus
);
  localparam int IDW = ($clog2(N_WORKERS) < 1) ? 1 : $clog2(N_WORKERS);
  localparam int PW  = $clog2(N_WORKERS) + 1;
  localparam logic [PW-1:0] DEPTH = PW'(N_WORKERS);
  localparam logic [PW-1:0] LAST  = PW'(N_WORKERS - 1);

  logic [IDW-1:0]       fifo [N_WORKERS];
  logic [W-1:0]         slot [N_WORKERS];
  logic [PW-1:0]        rd_ptr, wr_ptr, count, count_n;
  logic [N_WORKERS-1:0] outstanding, outstanding_n;
  logic [N_WORKERS-1:0] full, full_n, cap;
  logic [IDW-1:0]       head_id;
  logic                 pop, push, id_ok, id_busy, room, bad_res, err_evt;
  logic                 res_vld_q, busy_q, err_q;
  logic [W-1:0]         res_q;

  always_comb begin
    head_id = fifo[rd_ptr[IDW-1:0]];
    pop     = (count != '0) && full[head_id];
    id_ok   = int'(bus.issue_id) < N_WORKERS;
    // A worker whose outstanding bit is cleared by this cycle's pop is free
    // to be re-issued in the same cycle.
    id_busy = id_ok && outstanding[bus.issue_id] && !(pop && (head_id == bus.issue_id));
    room    = (count != DEPTH) || pop;
    push    = bus.issue_vld && id_ok && !id_busy && room;
    cap     = bus.wrk_res_vld & outstanding & ~full;
    bad_res = |(bus.wrk_res_vld & ~cap);
    err_evt = (bus.issue_vld && !push) || bad_res;

    outstanding_n = outstanding;
    full_n        = full | cap;
    if (pop) begin
      outstanding_n[head_id] = 1'b0;
      full_n[head_id]        = 1'b0;
    end
    if (push) outstanding_n[bus.issue_id] = 1'b1;

    count_n = count;
    if (push && !pop)      count_n = count + 1'b1;
    else if (!push && pop) count_n = count - 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      full        <= '0;
      res_vld_q   <= 1'b0;
      res_q       <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if (pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      if (push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      count       <= count_n;
      outstanding <= outstanding_n;
      full        <= full_n;
      res_vld_q   <= pop;
      if (pop) res_q <= slot[head_id];
      busy_q      <= (count_n != '0);
      err_q       <= err_q | err_evt;
    end
  end

  // Storage arrays carry no reset: validity lives in count/full flags.
  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr[IDW-1:0]] <= bus.issue_id;
    for (int unsigned k = 0; k < N_WORKERS; k++) begin
      if (cap[k]) slot[k] <= bus.wrk_res[k*W +: W];
    end
  end

  assign bus.res_vld = res_vld_q;
  assign bus.res     = res_q;
  assign bus.busy    = busy_q;
  assign bus.err     = err_q;
endmodule

// File: tb/tb_task_result_collector.sv
// Self-checking bench for task_result_collector: directed scenarios plus a
// randomized run, all checked cycle by cycle against a queue-based model.
module tb_task_result_collector;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  task_result_collector_if #(.N_WORKERS(4), .W(32)) bus ();
  task_result_collector_if #(.N_WORKERS(6), .W(8))  bus6 ();

  task_result_collector #(.N_WORKERS(4), .W(32)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );
  task_result_collector #(.N_WORKERS(6), .W(8)) dut6 (
    .clk(clk), .rst(rst), .bus(bus6.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: issue-order queue plus per-worker result bookkeeping.
  int          q[$];
  bit          outst[4];
  bit          has[4];
  logic [31:0] val[4];
  logic        exp_vld, exp_err;
  logic [31:0] exp_res;
  logic [31:0] rdat[4];
  logic [31:0] seen[$];

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < 4; i++) begin outst[i] = 0; has[i] = 0; end
    exp_vld = 0; exp_res = '0; exp_err = 0;
  endtask

  // Asynchronous reset pulse between clock edges; returns at a negedge
  // with rst released.
  task automatic do_reset();
    #2;
    rst = 1'b0;
    bus.issue_vld = 0; bus.issue_id = '0; bus.wrk_res_vld = '0; bus.wrk_res = '0;
    model_reset();
    #1;
    check("rst_res_vld", bus.res_vld, 0);
    check("rst_res",     bus.res, 0);
    check("rst_busy",    bus.busy, 0);
    check("rst_err",     bus.err, 0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Drive one cycle (called at a negedge), advance the model, compare after
  // the rising edge, and return at the following negedge.
  task automatic step(input bit iv, input int id, input logic [3:0] rv);
    bit pop;
    int h;
    bus.issue_vld   = iv;
    bus.issue_id    = 2'(id);
    bus.wrk_res_vld = rv;
    bus.wrk_res     = {rdat[3], rdat[2], rdat[1], rdat[0]};

    pop = (q.size() != 0) && has[q[0]];
    for (int k = 0; k < 4; k++) begin
      if (rv[k]) begin
        if (outst[k] && !has[k]) begin has[k] = 1; val[k] = rdat[k]; end
        else exp_err = 1;
      end
    end
    if (pop) begin
      h = q.pop_front();
      exp_vld = 1; exp_res = val[h]; has[h] = 0; outst[h] = 0;
    end else begin
      exp_vld = 0;
    end
    if (iv) begin
      if (id < 4 && !outst[id] && q.size() < 4) begin q.push_back(id); outst[id] = 1; end
      else exp_err = 1;
    end

    @(posedge clk);
    #1;
    check("res_vld", bus.res_vld, exp_vld);
    check("res",     bus.res, exp_res);
    check("busy",    bus.busy, q.size() != 0);
    check("err",     bus.err, exp_err);
    if (bus.res_vld) seen.push_back(bus.res);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 4'b0000);
  endtask

  initial begin
    bus6.issue_vld = 0; bus6.issue_id = '0; bus6.wrk_res_vld = '0; bus6.wrk_res = '0;
    for (int i = 0; i < 4; i++) rdat[i] = '0;
    do_reset();

    // Out-of-range ID on a 6-worker instance: 5 is legal, 6 is not.
    bus6.issue_vld = 1; bus6.issue_id = 3'd5;
    @(posedge clk); #1;
    check("n6_id5_err",  bus6.err, 0);
    check("n6_id5_busy", bus6.busy, 1);
    @(negedge clk);
    bus6.issue_id = 3'd6;
    @(posedge clk); #1;
    check("n6_id6_err", bus6.err, 1);
    @(negedge clk);
    bus6.issue_vld = 0;
    idle(2);
    check("n6_err_sticky", bus6.err, 1);

    // In-order completion after a long wait.
    seen.delete();
    step(1, 0, 0); step(1, 1, 0); step(1, 2, 0);
    idle(50);
    rdat[0] = 32'hA; step(0, 0, 4'b0001);
    rdat[1] = 32'hB; step(0, 0, 4'b0010);
    rdat[2] = 32'hC; step(0, 0, 4'b0100);
    idle(3);
    check("inord_n", seen.size(), 3);
    if (seen.size() == 3) begin
      check("inord_0", seen[0], 32'hA);
      check("inord_1", seen[1], 32'hB);
      check("inord_2", seen[2], 32'hC);
    end
    check("inord_busy", bus.busy, 0);

    // Reorder: completions 3,1,0,2.
    seen.delete();
    step(1, 0, 0); step(1, 1, 0); step(1, 2, 0); step(1, 3, 0);
    rdat[3] = 32'h30; step(0, 0, 4'b1000); idle(2);
    rdat[1] = 32'h10; step(0, 0, 4'b0010); idle(2);
    check("reord_none_yet", seen.size(), 0);
    rdat[0] = 32'h00; step(0, 0, 4'b0001); idle(2);
    rdat[2] = 32'h20; step(0, 0, 4'b0100); idle(4);
    check("reord_n", seen.size(), 4);
    if (seen.size() == 4) begin
      check("reord_0", seen[0], 32'h00);
      check("reord_1", seen[1], 32'h10);
      check("reord_2", seen[2], 32'h20);
      check("reord_3", seen[3], 32'h30);
    end

    // Simultaneous completion of workers 0 and 1.
    seen.delete();
    step(1, 1, 0); step(1, 0, 0);
    rdat[0] = 32'h1111; rdat[1] = 32'h2222; step(0, 0, 4'b0011);
    idle(3);
    check("simul_n", seen.size(), 2);
    if (seen.size() == 2) begin
      check("simul_0", seen[0], 32'h2222);
      check("simul_1", seen[1], 32'h1111);
    end

    // Full FIFO, head completes, head worker re-issued in the pop cycle.
    step(1, 0, 0); step(1, 1, 0); step(1, 2, 0); step(1, 3, 0);
    rdat[0] = 32'h55; step(0, 0, 4'b0001);
    step(1, 0, 0);
    check("full_reissue_err", bus.err, 0);
    step(1, 1, 0);
    check("full_no_room_err", bus.err, 1);
    do_reset();

    // Violations: re-issue to outstanding worker.
    step(1, 0, 0); step(1, 0, 0);
    check("viol_dup_err", bus.err, 1);
    rdat[0] = 32'hD0; step(0, 0, 4'b0001); idle(3);
    check("viol_dup_sticky", bus.err, 1);
    do_reset();
    // Spurious completion from idle worker; normal traffic still flows.
    step(1, 1, 0);
    rdat[2] = 32'hBAD; step(0, 0, 4'b0100);
    check("viol_spur_err", bus.err, 1);
    rdat[1] = 32'hE1; step(0, 0, 4'b0010); idle(3);
    do_reset();

    // Mid-run asynchronous reset while a result is on the output.
    step(1, 0, 0); step(1, 1, 0); step(1, 2, 0);
    rdat[0] = 32'h77; step(0, 0, 4'b0001);
    step(0, 0, 0);
    check("mid_pre_vld", bus.res_vld, 1);
    do_reset();
    rdat[1] = 32'h88; rdat[2] = 32'h99; step(0, 0, 4'b0110);
    check("stale_err", bus.err, 1);
    idle(4);
    do_reset();

    // Randomized legal traffic.
    for (int c = 0; c < 3000; c++) begin
      bit          pre_pop, iv, legal;
      int          id;
      logic [3:0]  rv;
      pre_pop = (q.size() != 0) && has[q[0]];
      iv = ($urandom_range(0, 2) != 0);
      id = $urandom_range(0, 3);
      legal = (!outst[id] || (pre_pop && id == q[0])) && (q.size() < 4 || pre_pop);
      if (!legal) iv = 0;
      rv = '0;
      for (int k = 0; k < 4; k++) begin
        rdat[k] = $urandom;
        if (outst[k] && !has[k] && $urandom_range(0, 3) == 0) rv[k] = 1'b1;
      end
      step(iv, id, rv);
    end
    idle(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
